audio_gate: RTL and testbench

AUDIO_GATE -- requirements
Module: audio_gate

---
 rtl/audio_gate.sv | 176 +++++++++++++++++
 tb/tb_audio_gate.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/audio_gate.sv
// Purpose: gates a square-wave tone onto an active-low speaker pin with an envelope-shaped, volume-capped 16-step PWM.
// Latency: sound_in reaches arduino after 3 clk edges (2 synchronizer flops + 1 output register); enable acts on the next edge.
// Backpressure: none; free-running streaming path with no flow control. Macro AUDIO_GATE_ENVELOPE_EN enables the stepped attack/release ramps.
module audio_gate #(
  parameter int unsigned STEP_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sound_in,
  input  logic       enable,
  input  logic [3:0] volume,
  output logic       arduino,
  output logic       busy,
  output logic [3:0] env_level
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ATTACK  = 2'd1,
    SUSTAIN = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t     state;
  logic       sound_a;
  logic       sound_s;
  logic [3:0] pwm_cnt;
  logic [3:0] vol_q;
  logic [3:0] eff;
  logic       pwm_on;

  // Elaboration-time guard: the step counter is 20 bits wide.
  if (STEP_CYCLES < 1 || STEP_CYCLES > 32'd1048576) begin : g_step_range_check
    $error("audio_gate: STEP_CYCLES must be in 1..2^20");
  end

  // Two-flop synchronizer for the tone, which comes from another clock domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      sound_a <= 1'b0;
      sound_s <= 1'b0;
    end else begin
      sound_a <= sound_in;
      sound_s <= sound_a;
    end
  end

  // Free-running PWM period counter; volume is sampled only at the period boundary
  // so a mid-period change never produces a truncated or stretched pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt <= 4'd0;
      vol_q   <= 4'd0;
    end else begin
      pwm_cnt <= pwm_cnt + 4'd1;
      if (pwm_cnt == 4'd15) begin
        vol_q <= volume;
      end
    end
  end

  // Effective duty is the lower of envelope and volume; 15 means fully on, since
  // a plain compare against a 0..15 counter could only reach 15/16.
  always_comb begin
    eff    = (env_level < vol_q) ? env_level : vol_q;
    pwm_on = 1'b0;
    if (eff == 4'd15) begin
      pwm_on = 1'b1;
    end else begin
      pwm_on = (pwm_cnt < eff);
    end
  end

  // Registered active-low speaker drive; idles high (silent).
  always_ff @(posedge clk) begin
    if (reset) begin
      arduino <= 1'b1;
    end else begin
      arduino <= ~(sound_s & pwm_on);
    end
  end

  assign busy = (state != IDLE);

`ifdef AUDIO_GATE_ENVELOPE_EN
  localparam logic [19:0] STEP_LAST = 20'(STEP_CYCLES - 1);

  logic [19:0] step_cnt;
  logic        step_due;

  assign step_due = (step_cnt == STEP_LAST);

  // Envelope FSM: enable changes are handled before a level step, so a cycle that
  // both changes direction and hits a step boundary leaves the level untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      env_level <= 4'd0;
      step_cnt  <= 20'd0;
    end else begin
      case (state)
        IDLE: begin
          env_level <= 4'd0;
          step_cnt  <= 20'd0;
          if (enable) begin
            state <= ATTACK;
          end
        end
        ATTACK: begin
          if (!enable) begin
            state    <= RELEASE;
            step_cnt <= 20'd0;
          end else if (env_level == 4'd15) begin
            // Re-entered from RELEASE while already at the top.
            state    <= SUSTAIN;
            step_cnt <= 20'd0;
          end else if (step_due) begin
            step_cnt  <= 20'd0;
            env_level <= env_level + 4'd1;
            if (env_level == 4'd14) begin
              state <= SUSTAIN;
            end
          end else begin
            step_cnt <= step_cnt + 20'd1;
          end
        end
        SUSTAIN: begin
          env_level <= 4'd15;
          step_cnt  <= 20'd0;
          if (!enable) begin
            state <= RELEASE;
          end
        end
        RELEASE: begin
          if (enable) begin
            state    <= ATTACK;
            step_cnt <= 20'd0;
          end else if (env_level == 4'd0) begin
            // Entered from ATTACK before the first step; nothing to ramp down.
            state    <= IDLE;
            step_cnt <= 20'd0;
          end else if (step_due) begin
            step_cnt  <= 20'd0;
            env_level <= env_level - 4'd1;
            if (env_level == 4'd1) begin
              state <= IDLE;
            end
          end else begin
            step_cnt <= step_cnt + 20'd1;
          end
        end
        default: begin
          state     <= IDLE;
          env_level <= 4'd0;
          step_cnt  <= 20'd0;
        end
      endcase
    end
  end
`else
  // Gate-only mode: enable snaps the level between 0 and 15 on the next edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      env_level <= 4'd0;
    end else if (enable) begin
      state     <= SUSTAIN;
      env_level <= 4'd15;
    end else begin
      state     <= IDLE;
      env_level <= 4'd0;
    end
  end
`endif

endmodule

// File: tb/tb_audio_gate.sv
// Directed bench for audio_gate with STEP_CYCLES=4, covering both envelope builds.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
// No flow control involved; every wait is a fixed or bounded cycle count.
module tb_audio_gate;

  logic       clk = 1'b0;
  logic       reset;
  logic       sound_in;
  logic       enable;
  logic [3:0] volume;
  logic       arduino;
  logic       busy;
  logic [3:0] env_level;

  int n_vec = 0;
  int n_bad = 0;
  int ph    = 0;   // expected pwm_cnt value after the most recent edge

  always #5 clk = ~clk;

  audio_gate #(.STEP_CYCLES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .sound_in  (sound_in),
    .enable    (enable),
    .volume    (volume),
    .arduino   (arduino),
    .busy      (busy),
    .env_level (env_level)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      ph = reset ? 0 : (ph + 1) % 16;
      #1;
    end
  endtask

  initial begin
    int ones;
    int zeros;
    int guard;
    logic exp_a;

    reset    = 1'b1;
    sound_in = 1'b0;
    enable   = 1'b0;
    volume   = 4'd0;
    tick(2);
    check("rst_env", env_level, 0);
    check("rst_busy", busy, 0);
    check("rst_arduino", arduino, 1);

    // Ramp to SUSTAIN with full volume and a steady tone.
    reset    = 1'b0;
    volume   = 4'd15;
    sound_in = 1'b1;
    enable   = 1'b1;
    tick(1);
    check("busy_after_en", busy, 1);
`ifdef AUDIO_GATE_ENVELOPE_EN
    check("att_start", env_level, 0);
    for (int k = 1; k <= 15; k++) begin
      tick(3);
      check("att_hold", env_level, k - 1);
      tick(1);
      check("att_step", env_level, k);
    end
`else
    check("gate_on", env_level, 15);
`endif
    tick(8);
    check("sus_level", env_level, 15);
    check("sus_busy", busy, 1);

    // Full volume: speaker driven every cycle.
    tick(20);
    ones = 0;
    for (int i = 0; i < 16; i++) begin
      tick(1);
      if (arduino) ones++;
    end
    check("full_on", ones, 0);

    // Tone edge reaches the pin three edges later.
    sound_in = 1'b0;
    tick(2);
    check("sync_fall_hold", arduino, 0);
    tick(1);
    check("sync_fall", arduino, 1);
    sound_in = 1'b1;
    tick(2);
    check("sync_rise_hold", arduino, 1);
    tick(1);
    check("sync_rise", arduino, 0);

    // Mid-period change to volume 8: rest of this period stays full-on.
    guard = 0;
    while (ph != 5 && guard < 20) begin
      tick(1);
      guard++;
    end
    check("phase_found", ph, 5);
    volume = 4'd8;
    ones   = 0;
    guard  = 0;
    do begin
      tick(1);
      guard++;
      if (arduino) ones++;
    end while (ph != 0 && guard < 20);
    check("vol_old_period", ones, 0);
    zeros = 0;
    for (int i = 0; i < 16; i++) begin
      tick(1);
      exp_a = (ph >= 1 && ph <= 8) ? 1'b0 : 1'b1;
      check("vol8_pwm", arduino, exp_a);
      if (!arduino) zeros++;
    end
    check("vol8_duty", zeros, 8);

    // Reset from SUSTAIN with enable still high.
    volume = 4'd15;
    reset  = 1'b1;
    tick(1);
    check("rst_sus_env", env_level, 0);
    check("rst_sus_busy", busy, 0);
    check("rst_sus_arduino", arduino, 1);

`ifdef AUDIO_GATE_ENVELOPE_EN
    // Attack to 6, then drop enable exactly on a step boundary.
    reset  = 1'b0;
    enable = 1'b1;
    tick(1);
    tick(24);
    check("att_lvl6", env_level, 6);
    tick(3);
    check("att_lvl6_pre", env_level, 6);
    enable = 1'b0;
    tick(1);
    check("coincide_no_step", env_level, 6);
    check("rel_busy", busy, 1);
    for (int k = 5; k >= 0; k--) begin
      tick(3);
      check("rel_hold", env_level, k + 1);
      tick(1);
      check("rel_step", env_level, k);
    end
    check("rel_idle_busy", busy, 0);
    tick(1);
    check("rel_idle_arduino", arduino, 1);
    check("rel_idle_level", env_level, 0);

    // Reset mid-ATTACK at level 10 aborts with no ramp-down.
    enable = 1'b1;
    tick(1);
    tick(40);
    check("att_lvl10", env_level, 10);
    reset = 1'b1;
    tick(1);
    check("rst_att_env", env_level, 0);
    check("rst_att_busy", busy, 0);
    check("rst_att_arduino", arduino, 1);
    reset = 1'b0;
    tick(1);
    check("restart_busy", busy, 1);
    tick(4);
    check("restart_step", env_level, 1);
`else
    // Gate-only mode: level snaps one edge after each enable change.
    reset  = 1'b0;
    enable = 1'b0;
    tick(1);
    check("gate_idle", env_level, 0);
    enable = 1'b1;
    tick(1);
    check("gate_rise_env", env_level, 15);
    check("gate_rise_busy", busy, 1);
    enable = 1'b0;
    tick(1);
    check("gate_fall_env", env_level, 0);
    check("gate_fall_busy", busy, 0);
`endif

    // Volume 0 keeps the speaker silent even with the envelope fully up.
    reset    = 1'b1;
    enable   = 1'b0;
    volume   = 4'd0;
    tick(1);
    reset    = 1'b0;
    enable   = 1'b1;
    sound_in = 1'b0;
    zeros    = 0;
    for (int i = 0; i < 100; i++) begin
      if (i % 3 == 0) sound_in = ~sound_in;
      tick(1);
      if (!arduino) zeros++;
    end
    check("vol0_silent", zeros, 0);
    check("vol0_env_up", env_level, 15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
